// File: rtl/mem_bus_pkg.sv
// Shared memory-bus definitions: command encoding, arbiter states, master ids.
package mem_bus_pkg;

    localparam logic [1:0] MWRITE = 2'b00;
    localparam logic [1:0] MREAD  = 2'b01;
    localparam logic [1:0] MNONE  = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } arb_state_t;

    typedef enum logic {
        CPU = 1'b0,
        DBG = 1'b1
    } master_t;

    // 2'b11 is not a request; it behaves like MNONE.
    function automatic logic is_request(input logic [1:0] cmd);
        return (cmd == MWRITE) || (cmd == MREAD);
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Master-side request port and shared memory bus bundles.
interface mem_port_if #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 16
);
    logic [1:0]        cmd;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              ready;

    modport master (output cmd, addr, wdata, input rdata, ready);
    modport slave  (input cmd, addr, wdata, output rdata, ready);
endinterface

interface mem_bus_if #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 16
);
    logic [1:0]        cmd;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;

    modport master (output cmd, addr, wdata, input rdata);
    modport slave  (input cmd, addr, wdata, output rdata);
endinterface

// File: rtl/mem_arbiter_rr_pick2.sv
// Two-way round-robin selector; on a tie the master not granted last wins.
module rr_pick2
    import mem_bus_pkg::*;
(
    input  logic [1:0] req,          // [0] = CPU, [1] = DBG
    input  master_t    last_grant,
    output logic       grant_valid,
    output master_t    grant_id
);

    // Pick the single requester, or alternate against last_grant on a tie.
    always_comb begin
        grant_valid = |req;
        grant_id    = CPU;
        if (req == 2'b11) begin
            grant_id = (last_grant == CPU) ? DBG : CPU;
        end else if (req[1]) begin
            grant_id = DBG;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the memory bus between CPU and debug master, one registered
// transaction at a time, with a one-cycle ready pulse to the winner.
//
//   state | meaning
//   IDLE  | sample requests, latch winner's transaction onto bus regs
//   ISSUE | bus shows the transaction for one cycle
//   RESP  | winner sees ready; read data captured at the closing edge
module mem_arbiter
    import mem_bus_pkg::*;
#(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 16
) (
    input  logic        clk,
    input  logic        reset,
    mem_port_if.slave   cpu,
    mem_port_if.slave   dbg,
    mem_bus_if.master   mem
);

    localparam logic [1:0] ST_IDLE  = IDLE;
    localparam logic [1:0] ST_ISSUE = ISSUE;
    localparam logic [1:0] ST_RESP  = RESP;

    logic [1:0]        state;
    master_t           winner;
    master_t           last_grant;
    logic              op_read;

    logic [1:0]        mem_cmd_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic [DATA_W-1:0] cpu_rdata_q;
    logic [DATA_W-1:0] dbg_rdata_q;
    logic              cpu_ready_q;
    logic              dbg_ready_q;

    logic [1:0]        req;
    logic              grant_valid;
    master_t           grant_id;

    assign req = {is_request(dbg.cmd), is_request(cpu.cmd)};

    rr_pick2 u_pick (
        .req         (req),
        .last_grant  (last_grant),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    // Arbitration FSM with bus, ready and read-data registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            winner      <= CPU;
            last_grant  <= DBG;
            op_read     <= 1'b0;
            mem_cmd_q   <= MNONE;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            cpu_rdata_q <= '0;
            dbg_rdata_q <= '0;
            cpu_ready_q <= 1'b0;
            dbg_ready_q <= 1'b0;
        end else begin
            cpu_ready_q <= 1'b0;
            dbg_ready_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (grant_valid) begin
                        winner <= grant_id;
                        if (grant_id == CPU) begin
                            mem_cmd_q   <= cpu.cmd;
                            mem_addr_q  <= cpu.addr;
                            mem_wdata_q <= cpu.wdata;
                            op_read     <= (cpu.cmd == MREAD);
                        end else begin
                            mem_cmd_q   <= dbg.cmd;
                            mem_addr_q  <= dbg.addr;
                            mem_wdata_q <= dbg.wdata;
                            op_read     <= (dbg.cmd == MREAD);
                        end
                        state <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    mem_cmd_q <= MNONE;
                    // ready is registered so it lines up exactly with RESP
                    if (winner == CPU) cpu_ready_q <= 1'b1;
                    else               dbg_ready_q <= 1'b1;
                    state <= ST_RESP;
                end
                ST_RESP: begin
                    if (op_read) begin
                        if (winner == CPU) cpu_rdata_q <= mem.rdata;
                        else               dbg_rdata_q <= mem.rdata;
                    end
                    last_grant <= winner;
                    state      <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign mem.cmd   = mem_cmd_q;
    assign mem.addr  = mem_addr_q;
    assign mem.wdata = mem_wdata_q;
    assign cpu.rdata = cpu_rdata_q;
    assign cpu.ready = cpu_ready_q;
    assign dbg.rdata = dbg_rdata_q;
    assign dbg.ready = dbg_ready_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus randomized traffic checked
// against a transaction-level model of the arbitration and memory.
module tb_mem_arbiter;
    import mem_bus_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int checks = 0;
    int errors = 0;

    mem_port_if #(.ADDR_W(9), .DATA_W(16)) cpu_if ();
    mem_port_if #(.ADDR_W(9), .DATA_W(16)) dbg_if ();
    mem_bus_if  #(.ADDR_W(9), .DATA_W(16)) bus_if ();

    mem_arbiter #(.ADDR_W(9), .DATA_W(16)) dut (
        .clk   (clk),
        .reset (reset),
        .cpu   (cpu_if),
        .dbg   (dbg_if),
        .mem   (bus_if)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] ram_init(input logic [8:0] a);
        return {4'hA, 3'b000, a};
    endfunction

    // Registered-read RAM with an LED register in the I/O region.
    logic [15:0] ram [512];
    logic [7:0]  led;
    initial begin
        for (int i = 0; i < 512; i++) ram[i] = ram_init(9'(i));
        led = 8'h00;
        bus_if.rdata = 16'h0;
    end
    always @(posedge clk) begin
        if (bus_if.cmd == MWRITE) begin
            ram[bus_if.addr] <= bus_if.wdata;
            if (bus_if.addr[8]) led <= bus_if.wdata[7:0];
        end else if (bus_if.cmd == MREAD) begin
            bus_if.rdata <= ram[bus_if.addr];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cpu_if.cmd = MNONE; cpu_if.addr = '0; cpu_if.wdata = '0;
        dbg_if.cmd = MNONE; dbg_if.addr = '0; dbg_if.wdata = '0;
        tick(); tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cpu_if.cmd = MNONE; dbg_if.cmd = MNONE;
        cpu_if.addr = '0; cpu_if.wdata = '0; dbg_if.addr = '0; dbg_if.wdata = '0;
        tick(); tick();
        checks++; if (bus_if.addr !== 9'h0 || bus_if.wdata !== 16'h0) begin errors++; $display("FAIL reset_bus got addr %h data %h exp 000 0000", bus_if.addr, bus_if.wdata); end
        reset = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            checks++; if (bus_if.cmd !== MNONE) begin errors++; $display("FAIL reset_idle_cmd c=%0d got %b exp 10", c, bus_if.cmd); end
            checks++; if (cpu_if.ready !== 1'b0 || dbg_if.ready !== 1'b0) begin errors++; $display("FAIL reset_idle_ready c=%0d got %b%b exp 00", c, cpu_if.ready, dbg_if.ready); end
            checks++; if (cpu_if.rdata !== 16'h0 || dbg_if.rdata !== 16'h0) begin errors++; $display("FAIL reset_rdata c=%0d got %h %h exp 0", c, cpu_if.rdata, dbg_if.rdata); end
        end
    endtask

    task automatic test_write_read();
        cpu_if.cmd = MWRITE; cpu_if.addr = 9'h005; cpu_if.wdata = 16'hBEEF;
        tick();
        checks++; if (bus_if.cmd !== MWRITE || bus_if.addr !== 9'h005 || bus_if.wdata !== 16'hBEEF) begin errors++; $display("FAIL wr_bus got %b %h %h exp 00 005 beef", bus_if.cmd, bus_if.addr, bus_if.wdata); end
        checks++; if (cpu_if.ready !== 1'b0) begin errors++; $display("FAIL wr_early_ready got %b exp 0", cpu_if.ready); end
        tick();
        checks++; if (cpu_if.ready !== 1'b1 || dbg_if.ready !== 1'b0) begin errors++; $display("FAIL wr_ready got %b%b exp 10", cpu_if.ready, dbg_if.ready); end
        tick();
        cpu_if.cmd = MREAD; cpu_if.addr = 9'h005;
        checks++; if (cpu_if.ready !== 1'b0) begin errors++; $display("FAIL wr_ready_pulse got %b exp 0", cpu_if.ready); end
        tick();
        checks++; if (bus_if.cmd !== MREAD || bus_if.addr !== 9'h005) begin errors++; $display("FAIL rd_bus got %b %h exp 01 005", bus_if.cmd, bus_if.addr); end
        tick();
        checks++; if (cpu_if.ready !== 1'b1) begin errors++; $display("FAIL rd_ready got %b exp 1", cpu_if.ready); end
        tick();
        cpu_if.cmd = MNONE;
        checks++; if (cpu_if.rdata !== 16'hBEEF) begin errors++; $display("FAIL rd_data got %h exp beef", cpu_if.rdata); end
    endtask

    task automatic test_dbg_io_write();
        dbg_if.cmd = MWRITE; dbg_if.addr = 9'h100; dbg_if.wdata = 16'h00A5;
        tick();
        checks++; if (bus_if.cmd !== MWRITE || bus_if.addr !== 9'h100 || bus_if.wdata !== 16'h00A5) begin errors++; $display("FAIL io_bus got %b %h %h exp 00 100 00a5", bus_if.cmd, bus_if.addr, bus_if.wdata); end
        tick();
        checks++; if (dbg_if.ready !== 1'b1 || cpu_if.ready !== 1'b0) begin errors++; $display("FAIL io_ready got cpu %b dbg %b exp 0 1", cpu_if.ready, dbg_if.ready); end
        tick();
        dbg_if.cmd = MNONE;
        checks++; if (led !== 8'hA5) begin errors++; $display("FAIL io_led got %h exp a5", led); end
        checks++; if (cpu_if.rdata !== 16'hBEEF) begin errors++; $display("FAIL io_cpu_rdata got %h exp beef", cpu_if.rdata); end
    endtask

    task automatic test_cmd11();
        cpu_if.cmd = 2'b11; dbg_if.cmd = MNONE;
        for (int c = 0; c < 4; c++) begin
            tick();
            checks++; if (bus_if.cmd !== MNONE || cpu_if.ready !== 1'b0) begin errors++; $display("FAIL cmd11 c=%0d got cmd %b ready %b exp 10 0", c, bus_if.cmd, cpu_if.ready); end
        end
        cpu_if.cmd = MNONE;
    endtask

    task automatic test_alternation();
        bit exp_c, exp_d;
        do_reset();
        cpu_if.cmd = MREAD; cpu_if.addr = 9'h010;
        dbg_if.cmd = MREAD; dbg_if.addr = 9'h020;
        for (int k = 1; k <= 11; k++) begin
            tick();
            exp_c = (k % 3 == 2) && ((k / 3) % 2 == 0);
            exp_d = (k % 3 == 2) && ((k / 3) % 2 == 1);
            checks++; if (cpu_if.ready !== exp_c || dbg_if.ready !== exp_d) begin errors++; $display("FAIL alt_ready k=%0d got %b%b exp %b%b", k, cpu_if.ready, dbg_if.ready, exp_c, exp_d); end
        end
        cpu_if.cmd = MNONE; dbg_if.cmd = MNONE;
        tick();
        checks++; if (cpu_if.rdata !== ram_init(9'h010) || dbg_if.rdata !== ram_init(9'h020)) begin errors++; $display("FAIL alt_rdata got %h %h exp %h %h", cpu_if.rdata, dbg_if.rdata, ram_init(9'h010), ram_init(9'h020)); end
    endtask

    task automatic test_reset_in_resp();
        do_reset();
        dbg_if.cmd = MREAD; dbg_if.addr = 9'h020;
        tick(); tick();
        reset = 1'b1;
        cpu_if.cmd = MWRITE; cpu_if.addr = 9'h005; cpu_if.wdata = 16'h1234;
        tick();
        checks++; if (dbg_if.ready !== 1'b0 || cpu_if.ready !== 1'b0) begin errors++; $display("FAIL rst_ready got %b%b exp 00", cpu_if.ready, dbg_if.ready); end
        checks++; if (dbg_if.rdata !== 16'h0 || bus_if.cmd !== MNONE) begin errors++; $display("FAIL rst_state got rdata %h cmd %b exp 0000 10", dbg_if.rdata, bus_if.cmd); end
        reset = 1'b0;
        tick();
        checks++; if (bus_if.cmd !== MWRITE || bus_if.addr !== 9'h005 || bus_if.wdata !== 16'h1234) begin errors++; $display("FAIL rst_cpu_first got %b %h %h exp 00 005 1234", bus_if.cmd, bus_if.addr, bus_if.wdata); end
        tick();
        checks++; if (cpu_if.ready !== 1'b1 || dbg_if.ready !== 1'b0) begin errors++; $display("FAIL rst_cpu_ready got %b%b exp 10", cpu_if.ready, dbg_if.ready); end
        tick();
        cpu_if.cmd = MNONE;
        tick();
        checks++; if (bus_if.cmd !== MREAD || bus_if.addr !== 9'h020) begin errors++; $display("FAIL rst_dbg_next got %b %h exp 01 020", bus_if.cmd, bus_if.addr); end
        tick();
        checks++; if (dbg_if.ready !== 1'b1) begin errors++; $display("FAIL rst_dbg_ready got %b exp 1", dbg_if.ready); end
        tick();
        dbg_if.cmd = MNONE;
        checks++; if (dbg_if.rdata !== ram_init(9'h020)) begin errors++; $display("FAIL rst_dbg_rdata got %h exp %h", dbg_if.rdata, ram_init(9'h020)); end
    endtask

    // Random traffic in 040..05F against a transaction-level model.
    task automatic test_random();
        logic [1:0]  t_cmd   [2];
        logic [8:0]  t_addr  [2];
        logic [15:0] t_wdata [2];
        logic [15:0] exp_rd  [2];
        logic [15:0] ref_mem [512];
        bit          pend    [2];
        int          prev;
        int          win;
        do_reset();
        for (int i = 0; i < 512; i++) ref_mem[i] = ram_init(9'(i));
        for (int m = 0; m < 2; m++) begin
            t_cmd[m] = MNONE; t_addr[m] = '0; t_wdata[m] = '0; exp_rd[m] = '0; pend[m] = 1'b0;
        end
        prev = 1;
        for (int r = 0; r < 80; r++) begin
            for (int m = 0; m < 2; m++) begin
                if (!pend[m]) begin
                    case ($urandom_range(0, 5))
                        0, 1:    t_cmd[m] = MWRITE;
                        2, 3:    t_cmd[m] = MREAD;
                        4:       t_cmd[m] = MNONE;
                        default: t_cmd[m] = 2'b11;
                    endcase
                    t_addr[m]  = 9'h040 + 9'($urandom_range(0, 31));
                    t_wdata[m] = 16'($urandom);
                end
                pend[m] = (t_cmd[m] == MWRITE) || (t_cmd[m] == MREAD);
            end
            cpu_if.cmd = t_cmd[0]; cpu_if.addr = t_addr[0]; cpu_if.wdata = t_wdata[0];
            dbg_if.cmd = t_cmd[1]; dbg_if.addr = t_addr[1]; dbg_if.wdata = t_wdata[1];
            if (!pend[0] && !pend[1]) begin
                tick();
                checks++; if (bus_if.cmd !== MNONE || cpu_if.ready !== 1'b0 || dbg_if.ready !== 1'b0) begin errors++; $display("FAIL rnd_idle r=%0d got cmd %b ready %b%b exp 10 00", r, bus_if.cmd, cpu_if.ready, dbg_if.ready); end
                continue;
            end
            win = (pend[0] && pend[1]) ? 1 - prev : (pend[0] ? 0 : 1);
            tick();
            checks++; if (bus_if.cmd !== t_cmd[win] || bus_if.addr !== t_addr[win] || bus_if.wdata !== t_wdata[win]) begin errors++; $display("FAIL rnd_bus r=%0d got %b %h %h exp %b %h %h", r, bus_if.cmd, bus_if.addr, bus_if.wdata, t_cmd[win], t_addr[win], t_wdata[win]); end
            tick();
            checks++; if (cpu_if.ready !== (win == 0) || dbg_if.ready !== (win == 1) || bus_if.cmd !== MNONE) begin errors++; $display("FAIL rnd_ready r=%0d got %b%b cmd %b exp win %0d", r, cpu_if.ready, dbg_if.ready, bus_if.cmd, win); end
            if (t_cmd[win] == MWRITE) ref_mem[t_addr[win]] = t_wdata[win];
            else exp_rd[win] = ref_mem[t_addr[win]];
            prev = win;
            pend[win] = 1'b0;
            t_cmd[win] = MNONE;
            tick();
            cpu_if.cmd = t_cmd[0]; dbg_if.cmd = t_cmd[1];
            checks++; if (cpu_if.rdata !== exp_rd[0] || dbg_if.rdata !== exp_rd[1]) begin errors++; $display("FAIL rnd_rdata r=%0d got %h %h exp %h %h", r, cpu_if.rdata, dbg_if.rdata, exp_rd[0], exp_rd[1]); end
        end
        cpu_if.cmd = MNONE; dbg_if.cmd = MNONE;
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_dbg_io_write();
        test_cmd11();
        test_alternation();
        test_reset_in_resp();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
